// File: rtl/my_parity_acc.sv
// +-----------------------------------------------------------------------------+
// | my_parity_acc: serial parity accumulator that XORs a framed 1-bit stream.    |
// | Optional: MY_PARITY_ACC_CHECK_EN adds the exp_parity/err compare port pair.  |
// | Revision: 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module my_parity_acc #(
  parameter int FRAME_LEN  = 8,
  parameter int CNT_W      = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
`ifdef MY_PARITY_ACC_CHECK_EN
  input  logic             exp_parity,
  output logic             err,
`endif
  output logic             busy,
  output logic             done,
  output logic             parity_out,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] c_frame = CNT_W'(FRAME_LEN);
  localparam logic             c_seed  = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

  state_t           r_state;
  logic             r_acc;
  logic             r_busy;
  logic             r_done;
  logic             r_parity;
  logic [CNT_W-1:0] r_bit_cnt;
`ifdef MY_PARITY_ACC_CHECK_EN
  logic             r_err;
`endif

  logic w_fold;
  logic w_last;

  assign w_fold = r_acc ^ din;
  assign w_last = din_valid && (r_bit_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
`ifdef MY_PARITY_ACC_CHECK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= S_ACC;
            r_busy    <= 1'b1;
            r_acc     <= c_seed;
            r_bit_cnt <= '0;
          end
        end
        S_ACC: begin
          if (din_valid) begin
            r_acc <= w_fold;
            if (w_last) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_parity  <= w_fold;
              r_bit_cnt <= c_frame;
`ifdef MY_PARITY_ACC_CHECK_EN
              r_err     <= (w_fold != exp_parity);
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          // Reseed straight from DONE so back-to-back frames need no idle cycle.
          if (start) begin
            r_state   <= S_ACC;
            r_busy    <= 1'b1;
            r_acc     <= c_seed;
            r_bit_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign parity_out = r_parity;
  assign bit_cnt    = r_bit_cnt;
`ifdef MY_PARITY_ACC_CHECK_EN
  assign err        = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_my_parity_acc.sv
// +-----------------------------------------------------------------------------+
// | tb_my_parity_acc: directed bench driving an even and an odd accumulator.    |
// | Optional: MY_PARITY_ACC_CHECK_EN enables the exp_parity/err checks.          |
// | Revision: 1.0 - initial release                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_my_parity_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       din;
  logic       din_valid;
  logic       busy_e, done_e, parity_e;
  logic       busy_o, done_o, parity_o;
  logic [3:0] cnt_e, cnt_o;
`ifdef MY_PARITY_ACC_CHECK_EN
  logic       exp_par_e, exp_par_o;
  logic       err_e, err_o;
  logic       exp_err;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  logic pe, po;

  always #5 clk = ~clk;

  my_parity_acc #(.FRAME_LEN(8), .CNT_W(4), .ODD_PARITY(0)) dut_e (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
`ifdef MY_PARITY_ACC_CHECK_EN
    .exp_parity(exp_par_e), .err(err_e),
`endif
    .busy(busy_e), .done(done_e), .parity_out(parity_e), .bit_cnt(cnt_e)
  );

  my_parity_acc #(.FRAME_LEN(8), .CNT_W(4), .ODD_PARITY(1)) dut_o (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
`ifdef MY_PARITY_ACC_CHECK_EN
    .exp_parity(exp_par_o), .err(err_o),
`endif
    .busy(busy_o), .done(done_o), .parity_out(parity_o), .bit_cnt(cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outputs of both instances against the expected handshake and held parity.
  task automatic check_state(input string tag, input logic b, input logic d, input logic [3:0] c);
    check({tag, ".busy_e"}, 32'(busy_e), 32'(b));
    check({tag, ".busy_o"}, 32'(busy_o), 32'(b));
    check({tag, ".done_e"}, 32'(done_e), 32'(d));
    check({tag, ".done_o"}, 32'(done_o), 32'(d));
    check({tag, ".cnt_e"}, 32'(cnt_e), 32'(c));
    check({tag, ".cnt_o"}, 32'(cnt_o), 32'(c));
    check({tag, ".par_e"}, 32'(parity_e), 32'(pe));
    check({tag, ".par_o"}, 32'(parity_o), 32'(po));
`ifdef MY_PARITY_ACC_CHECK_EN
    check({tag, ".err_e"}, 32'(err_e), 32'(exp_err));
    check({tag, ".err_o"}, 32'(err_o), 32'(exp_err));
`endif
  endtask

  task automatic do_start(input string tag, input logic with_din);
    start     = 1'b1;
    din_valid = with_din;
    din       = 1'b1;
    tick();
    start     = 1'b0;
    din_valid = 1'b0;
    check_state({tag, ".start"}, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic feed(input string tag, input logic [7:0] bits, input int gap,
                      input logic exp_even, input logic flip, input logic start_mid);
`ifdef MY_PARITY_ACC_CHECK_EN
    exp_par_e = exp_even ^ flip;
    exp_par_o = ~exp_even ^ flip;
`endif
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        din_valid = 1'b0;
        tick();
        check_state({tag, ".gap"}, 1'b1, 1'b0, 4'(i));
      end
      din       = bits[7-i];
      din_valid = 1'b1;
      if (start_mid && i == 3) start = 1'b1;
      tick();
      din_valid = 1'b0;
      start     = 1'b0;
      if (i < 7) check_state({tag, ".bit"}, 1'b1, 1'b0, 4'(i + 1));
    end
    pe = exp_even;
    po = ~exp_even;
`ifdef MY_PARITY_ACC_CHECK_EN
    exp_err = flip;
`endif
    check_state({tag, ".done"}, 1'b0, 1'b1, 4'd8);
  endtask

  task automatic idle_tick(input string tag);
    tick();
    check_state({tag, ".idle"}, 1'b0, 1'b0, 4'd8);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    pe        = 1'b0;
    po        = 1'b0;
`ifdef MY_PARITY_ACC_CHECK_EN
    exp_par_e = 1'b0;
    exp_par_o = 1'b0;
    exp_err   = 1'b0;
`endif
    tick();
    tick();
    check_state("reset", 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    check_state("post_reset", 1'b0, 1'b0, 4'd0);

    // Frame A: 4 ones; din_valid alongside start must not be taken as a bit.
    do_start("A", 1'b1);
    feed("A", 8'b1011_0010, 0, 1'b0, 1'b0, 1'b0);
    idle_tick("A1");
    idle_tick("A2");

    // Frame B: 5 ones, then back-to-back into an all-zero frame.
    do_start("B", 1'b0);
    feed("B", 8'b1011_0011, 0, 1'b1, 1'b0, 1'b0);
    do_start("B2B", 1'b0);
    feed("Z", 8'b0000_0000, 0, 1'b0, 1'b0, 1'b0);
    idle_tick("Z");

    // All-zero frame with a valid bit only every third cycle.
    do_start("G", 1'b0);
    feed("G", 8'b0000_0000, 2, 1'b0, 1'b0, 1'b0);
    idle_tick("G");

    // Partial frame of 5 bits, then an asynchronous reset between edges.
    do_start("R", 1'b0);
    for (int i = 0; i < 5; i++) begin
      din       = (i == 3) ? 1'b0 : 1'b1;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      check_state("R.bit", 1'b1, 1'b0, 4'(i + 1));
    end
    #1 rst = 1'b1;
    #1;
    pe = 1'b0;
    po = 1'b0;
`ifdef MY_PARITY_ACC_CHECK_EN
    exp_err = 1'b0;
`endif
    check_state("R.async", 1'b0, 1'b0, 4'd0);
    #1 rst = 1'b0;
    // Valid data with no start: an IDLE machine must not count it.
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    tick();
    din_valid = 1'b0;
    check_state("R.idle", 1'b0, 1'b0, 4'd0);

    // Fresh frame after reset with start pulsed mid-frame.
    do_start("P", 1'b0);
    feed("P", 8'b1110_0000, 0, 1'b1, 1'b0, 1'b1);
    idle_tick("P");

    // Frame with deliberately wrong expected parity; err is held afterwards.
    do_start("E", 1'b0);
    feed("E", 8'b1011_0011, 0, 1'b1, 1'b1, 1'b0);
    idle_tick("E1");
    idle_tick("E2");
    idle_tick("E3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
